// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline buffers.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

   typedef enum logic [1:0] {
      IF_ID  = 2'd0,
      ID_EX  = 2'd1,
      EX_MEM = 2'd2,
      MEM_WB = 2'd3
   } stage_e;

   // Every control field of a stage bundle is active-high, so all-zero is a NOP.
   localparam logic NOP_BIT  = 1'b0;
   localparam int   STALL_CW = 16;

   // Packed bundle width at each stage boundary.
   function automatic int stage_width(input stage_e s);
      case (s)
         IF_ID:   return 64;
         ID_EX:   return 154;
         EX_MEM:  return 139;
         default: return 71;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (en && (count_reg != {CW{1'b1}})) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_buffer.sv
// Pipeline stage buffer with valid/ready handshake, flush and stall counter.
// Define PIPE_BUF_SKID_EN for the two-entry skid version with registered InReady.
module pipe_buffer
   import pipe_pkg::*;
#(
   parameter int             W      = stage_width(IF_ID),
   parameter int             CW     = STALL_CW,
   parameter logic [W-1:0]   BUBBLE = {W{NOP_BIT}}
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Flush,
   input  logic          InValid,
   output logic          InReady,
   input  logic [W-1:0]  InData,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [W-1:0]  OutData,
   output logic [CW-1:0] StallCnt
);

   buf_state_e   state_reg;
   logic [W-1:0] main_reg;
   logic         out_valid_reg;
   logic         in_xfer;
   logic         out_xfer;

`ifdef PIPE_BUF_SKID_EN
   logic [W-1:0] skid_reg;
   logic         in_ready_reg;

   // Ready comes straight from a flop so a downstream stall never reaches upstream in the same cycle.
   assign InReady = in_ready_reg;
`else
   assign InReady = ~out_valid_reg | OutReady;
`endif

   assign in_xfer  = InValid & InReady;
   assign out_xfer = out_valid_reg & OutReady;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_reg     <= EMPTY;
         main_reg      <= BUBBLE;
         out_valid_reg <= 1'b0;
`ifdef PIPE_BUF_SKID_EN
         skid_reg      <= BUBBLE;
         in_ready_reg  <= 1'b1;
`endif
      end else if (Flush) begin
         // Any bundle offered this cycle is dropped; an out-transfer still completes.
         state_reg     <= EMPTY;
         main_reg      <= BUBBLE;
         out_valid_reg <= 1'b0;
`ifdef PIPE_BUF_SKID_EN
         skid_reg      <= BUBBLE;
         in_ready_reg  <= 1'b1;
`endif
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_xfer) begin
                  state_reg     <= BUSY;
                  main_reg      <= InData;
                  out_valid_reg <= 1'b1;
               end
            end
            BUSY: begin
               if (in_xfer && out_xfer) begin
                  main_reg <= InData;
`ifdef PIPE_BUF_SKID_EN
               end else if (in_xfer) begin
                  state_reg    <= FULL;
                  skid_reg     <= InData;
                  in_ready_reg <= 1'b0;
`endif
               end else if (out_xfer) begin
                  state_reg     <= EMPTY;
                  main_reg      <= BUBBLE;
                  out_valid_reg <= 1'b0;
               end
            end
`ifdef PIPE_BUF_SKID_EN
            FULL: begin
               if (out_xfer) begin
                  state_reg    <= BUSY;
                  main_reg     <= skid_reg;
                  skid_reg     <= BUBBLE;
                  in_ready_reg <= 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

   assign OutValid = out_valid_reg;
   assign OutData  = main_reg;

   sat_counter #(
      .CW (CW)
   ) u_stall_cnt (
      .clk   (Clk),
      .rst   (Rst),
      .en    (out_valid_reg & ~OutReady),
      .count (StallCnt)
   );

endmodule

// File: tb/tb_pipe_buffer.sv
// Self-checking bench for pipe_buffer; follows PIPE_BUF_SKID_EN to pick the build under test.
module tb_pipe_buffer;

   localparam int           W    = 16;
   localparam int           CW   = 4;
   localparam int           SAT  = (1 << CW) - 1;
   localparam logic [W-1:0] BUB  = '0;
`ifdef PIPE_BUF_SKID_EN
   localparam bit           SKID = 1'b1;
`else
   localparam bit           SKID = 1'b0;
`endif

   logic          Clk = 1'b0;
   logic          Rst;
   logic          Flush;
   logic          InValid;
   logic          InReady;
   logic [W-1:0]  InData;
   logic          OutValid;
   logic          OutReady;
   logic [W-1:0]  OutData;
   logic [CW-1:0] StallCnt;

   int           compared   = 0;
   int           mismatched = 0;
   logic [W-1:0] q [$];
   int           exp_stall  = 0;

   pipe_buffer #(
      .W  (W),
      .CW (CW)
   ) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Flush    (Flush),
      .InValid  (InValid),
      .InReady  (InReady),
      .InData   (InData),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .OutData  (OutData),
      .StallCnt (StallCnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
      InValid  = v;
      InData   = d;
      OutReady = r;
      Flush    = f;
   endtask

   // One clock cycle: compare DUT against the queue model, then update the model for this edge.
   task automatic tick(input string tag);
      logic exp_valid;
      logic exp_ready;
      logic in_x;
      logic out_x;
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = SKID ? (q.size() < 2) : (!exp_valid || OutReady);
      chk({tag, ":OutValid"}, 32'(OutValid), 32'(exp_valid));
      chk({tag, ":InReady"},  32'(InReady),  32'(exp_ready));
      chk({tag, ":OutData"},  32'(OutData),  32'(exp_valid ? q[0] : BUB));
      chk({tag, ":StallCnt"}, 32'(StallCnt), 32'(exp_stall));
      in_x  = InValid && exp_ready && !Flush;
      out_x = exp_valid && OutReady;
      if (exp_valid && !OutReady && exp_stall < SAT) exp_stall++;
      if (out_x) void'(q.pop_front());
      if (Flush) q.delete();
      else if (in_x) q.push_back(InData);
      $display("cycle %-16s in=%0b/%0b/%h out=%0b/%0b/%h flush=%0b stall=%0d",
               tag, InValid, InReady, InData, OutValid, OutReady, OutData, Flush, StallCnt);
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (2) @(posedge Clk);
      #1;
      chk("reset:OutValid", 32'(OutValid), 32'(0));
      chk("reset:OutData",  32'(OutData),  32'(BUB));
      chk("reset:StallCnt", 32'(StallCnt), 32'(0));
      chk("reset:InReady",  32'(InReady),  32'(1));
      Rst = 1'b0;

      // Back-to-back stream 1..5 with the consumer always ready.
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, W'(i), 1'b1, 1'b0);
         tick("stream");
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      tick("stream_drain");
      tick("stream_idle");

      // Back-pressure while a second bundle is offered.
      drive(1'b1, 16'h000A, 1'b0, 1'b0);
      tick("bp_a");
      drive(1'b1, 16'h000B, 1'b0, 1'b0);
      tick("bp_b");
      chk("bp:InReady_low", 32'(InReady), 32'(0));
`ifdef PIPE_BUF_SKID_EN
      drive(1'b0, '0, 1'b1, 1'b0);
      tick("bp_out_a");
      tick("bp_out_b");
`else
      drive(1'b1, 16'h000B, 1'b1, 1'b0);
      tick("bp_out_a_in_b");
      drive(1'b0, '0, 1'b1, 1'b0);
      tick("bp_out_b");
`endif
      tick("bp_idle");

      // Flush with the buffer loaded and a fresh bundle offered.
      drive(1'b1, 16'h000A, 1'b0, 1'b0);
      tick("fl_a");
`ifdef PIPE_BUF_SKID_EN
      drive(1'b1, 16'h000B, 1'b0, 1'b0);
      tick("fl_b");
`endif
      drive(1'b1, 16'h000C, 1'b0, 1'b1);
      tick("fl_flush");
      chk("fl:OutValid", 32'(OutValid), 32'(0));
      chk("fl:OutData",  32'(OutData),  32'(BUB));
      drive(1'b0, '0, 1'b1, 1'b0);
      repeat (3) tick("fl_idle");

      // Long stall: counter saturates, flush leaves it alone.
      drive(1'b1, 16'h005A, 1'b0, 1'b0);
      tick("sat_load");
      drive(1'b0, '0, 1'b0, 1'b0);
      repeat (20) tick("sat_stall");
      chk("sat:StallCnt", 32'(StallCnt), 32'(SAT));
      drive(1'b0, '0, 1'b0, 1'b1);
      tick("sat_flush");
      chk("sat:StallCnt_after_flush", 32'(StallCnt), 32'(SAT));

      // Flush together with OutReady: the presented bundle still transfers.
      drive(1'b1, 16'h0011, 1'b1, 1'b0);
      tick("flo_load");
      drive(1'b0, '0, 1'b1, 1'b1);
      tick("flo_flush");
      chk("flo:OutValid", 32'(OutValid), 32'(0));

      // Asynchronous reset between clock edges.
      drive(1'b1, 16'h0021, 1'b0, 1'b0);
      tick("ar_a");
`ifdef PIPE_BUF_SKID_EN
      drive(1'b1, 16'h0022, 1'b0, 1'b0);
      tick("ar_b");
`endif
      #3;
      Rst = 1'b1;
      #1;
      chk("arst:OutValid", 32'(OutValid), 32'(0));
      chk("arst:OutData",  32'(OutData),  32'(BUB));
      chk("arst:StallCnt", 32'(StallCnt), 32'(0));
      chk("arst:InReady",  32'(InReady),  32'(1));
      q.delete();
      exp_stall = 0;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      drive(1'b1, 16'h0033, 1'b1, 1'b0);
      tick("post_rst");
      drive(1'b0, '0, 1'b1, 1'b0);
      tick("post_rst_drain");
      tick("post_rst_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipe_buffer.md
# pipe_buffer

Parametrised pipeline stage buffer with a valid/ready handshake, synchronous flush and a saturating stall counter. It replaces the fixed-width free-running inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) so that each stage can stall, be flushed with a bubble on a taken branch, and absorb back-pressure without losing data. One instance sits between each pair of adjacent pipeline stages of the datapath.

## Interface

Parameters:
- W, 64: width of the packed stage bundle (InData/OutData).
- CW, 16: width of the stall counter.
- BUBBLE, {W{1'b0}}: value loaded into the data registers on reset, flush or drain. All-zero is a NOP with every control bit deasserted.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Flush  in  1  synchronous flush request; inserts a bubble.
- InValid  in  1  upstream bundle valid.
- InReady  out  1  buffer can accept a bundle this cycle.
- InData  in  W  upstream bundle.
- OutValid  out  1  downstream bundle valid.
- OutReady  in  1  downstream accepts the bundle this cycle.
- OutData  out  W  registered bundle to the next stage.
- StallCnt  out  CW  count of cycles with OutValid & ~OutReady.

## Operation

- Transfer in: InValid & InReady at the clock edge. Transfer out: OutValid & OutReady at the clock edge.
- Storage: main register `main` (drives OutData), plus a skid register `skid` when PIPE_BUF_SKID_EN is defined.
- States (skid build): EMPTY (0 entries), BUSY (main valid), FULL (main and skid valid).
  - EMPTY: in -> BUSY, with main <= InData.
  - BUSY, in & out -> BUSY, with main <= InData.
  - BUSY, in only -> FULL, with skid <= InData.
  - BUSY, out only -> EMPTY, with main <= BUBBLE.
  - FULL: InReady = 0. out -> BUSY, with main <= skid and skid <= BUBBLE.
  - Any other case holds the current state.
- Outputs: OutValid = (state != EMPTY). OutData = main. OutData = BUBBLE whenever the buffer is EMPTY.
- Flush has the highest priority below Rst:
  - Next state is EMPTY; main and skid <= BUBBLE.
  - A bundle presented on the flush cycle is discarded, even if InReady = 1.
  - Flush does not clear StallCnt.
- StallCnt increments by 1 on every cycle with OutValid & ~OutReady. It saturates at 2^CW−1 and never wraps. It is cleared only by Rst.
- Reset values (asynchronous):
  - state = EMPTY; main = skid = BUBBLE.
  - OutValid = 0; OutData = BUBBLE; StallCnt = 0.
  - InReady = 1.
- Reset asserted mid-transfer loses every stored bundle. The first accept after Rst deasserts occurs on the first rising edge with Rst low.

## Timing

- Latency: 1 cycle from an in-transfer edge to OutValid/OutData.
- Throughput: 1 bundle per cycle whenever OutReady is held high.
- Skid build: InReady is a registered signal, InReady = (state != FULL), with no combinational path from OutReady. If OutReady drops, one extra bundle is absorbed; InReady drops the following cycle.
- Non-skid build: InReady = ~OutValid | OutReady. This is a combinational path from OutReady.
- Flush asserted together with OutReady: the bundle currently on OutData still counts as transferred that cycle. The next cycle presents OutValid = 0.

## Configuration

- PIPE_BUF_SKID_EN defined:
  - Two-entry buffer with states EMPTY/BUSY/FULL and the skid register.
  - Registered InReady; stalls do not propagate combinationally upstream.
- Undefined:
  - Single-entry buffer with states EMPTY/BUSY; no skid register.
  - Combinational InReady as above; FULL is unreachable.
  - Same reset, flush and counter behaviour.

## Structure

- Package pipe_pkg:
  - State enum (EMPTY, BUSY, FULL).
  - NOP bundle constant used as BUBBLE.
  - Packed bundle width constants for the four stage boundaries: 64, 154, 139 and 71 bits.
- Sub-module sat_counter #(CW): enable in, saturating count out, asynchronous active-high reset. Instantiated once for StallCnt.

## Test plan

- Reset release, OutReady = 1, InValid = 1 with InData = 0x1 to 0x5 on consecutive cycles -> OutData = 0x1 to 0x5 one cycle later each, OutValid continuous, StallCnt = 0.
- Skid build: BUSY holding 0xA, then OutReady = 0 while 0xB is offered -> 0xB is accepted and state is FULL. InReady = 0 the next cycle. OutReady = 1 then yields 0xA followed by 0xB, with no loss or duplication.
- Flush while FULL (0xA, 0xB) with InValid = 1, InData = 0xC -> next cycle OutValid = 0 and OutData = BUBBLE. 0xA, 0xB and 0xC never appear.
- OutValid held high with OutReady = 0 for 20 cycles, CW = 4 -> StallCnt reaches 15 and stays at 15. Flush leaves the count at 15.
- Rst asserted asynchronously mid-cycle while FULL -> OutValid = 0, OutData = BUBBLE, StallCnt = 0 immediately, without waiting for a clock edge.
- Non-skid build: BUSY, OutReady = 1 and InValid = 1 in the same cycle -> InReady = 1 combinationally and main is reloaded, giving back-to-back transfers with no bubble.
